hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Generates the 2-bit operand selects for the EX-stage forwarding muxes (A and B) and the
//  load-use stall/bubble controls for the 5-stage MIPS pipeline. Sits between ID and EX:
//  keeps its own EX/MEM/WB destination-tag pipeline and issues selects registered alongside
//  ID/EX, so they are valid during the consuming instruction's EX cycle.
// PARAMETERS
//  NB_REG   5   register-index width
//  NB_CNT   16  width of stall-event counter (read by debug unit)
// PORTS
//  i_clock          in   1       pipeline clock, rising edge
//  i_reset          in   1       asynchronous, active-low reset
//  i_enable         in   1       pipeline advance (debug step/run); 0 = freeze all state
//  i_id_valid       in   1       ID holds a real instruction
//  i_id_rs          in   NB_REG  source register A of ID instruction
//  i_id_rt          in   NB_REG  source register B of ID instruction
//  i_id_rd          in   NB_REG  destination after RegDst mux
//  i_id_regWrite    in   1       ID instruction writes register file
//  i_id_memRead     in   1       ID instruction is a load
//  i_flush          in   1       branch/jump taken: discard ID instruction
//  o_stall          out  1       hold PC and IF/ID (combinational)
//  o_bubble         out  1       zero ID/EX controls this cycle (combinational)
//  o_fwdA           out  2       select for operand A mux, registered
//  o_fwdB           out  2       select for operand B mux, registered
//  o_stall_count    out  NB_CNT  saturating count of load-use stalls
// BEHAVIOUR
//  - Reset: tag stages EX/MEM/WB valid=0, o_fwdA=o_fwdB=2'b00, o_stall_count=0;
//    o_stall=o_bubble=0 as a consequence.
//  - Tag stage = {valid, rd, regWrite, memRead}. Match(stage,r) = valid & regWrite & rd==r & r!=0.
//  - hazard = i_id_valid & EX.valid & EX.memRead & EX.rd!=0 & (EX.rd==rs | EX.rd==rt).
//  - o_stall = hazard & ~i_flush. o_bubble = hazard | i_flush.
//  - On rising edge with i_enable=1: WB<=MEM; MEM<=EX;
//    EX <= o_bubble | ~i_id_valid ? invalid tag : ID tag.
//  - Select computed at issue, per operand r (rs->A, rt->B), newest-first priority:
//    Match(EX,r) -> 2'b01 (MEM, since producer is in MEM during consumer EX);
//    else Match(MEM,r) -> 2'b10 (WB); else 2'b00 (register-file value).
//    On bubble/flush the registered selects load 2'b00. 2'b11 never driven.
//  - After one stall cycle the load has moved to MEM; the reissued consumer gets 2'b10.
//    Exactly one stall cycle per load-use; stall never lasts two cycles for one load.
//  - Register $0 is never forwarded nor stalled on, regardless of regWrite.
//  - WB-to-ID same-cycle hazard is not handled here: register file writes on negedge.
//  - i_flush and hazard in same cycle: flush wins, o_stall=0, counter not incremented.
//  - o_stall_count increments on each enabled edge with o_stall=1; saturates at all-ones.
//  - i_enable=0: all registers hold; o_stall/o_bubble still reflect current inputs.
//  - Reset asserted mid-stall: all stages cleared immediately, stall drops asynchronously.
// STRUCTURE
//  - Shared package/header: FWD_ID=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10 (also used by the
//    EX forwarding muxes), NB_REG.
//  - One sub-module: hazard_tag_stage (one-stage {valid,rd,regWrite,memRead} register with
//    enable, async active-low reset); instantiated three times. Match/select logic inline.
// TESTING
//  1 add $3,$1,$2 then sub $4,$3,$5 -> second issue: o_fwdA=01, o_fwdB=00, no stall.
//  2 add $3,.. ; nop ; or $6,$7,$3 -> or issues with o_fwdB=10, o_fwdA=00.
//  3 lw $2,0($1) then add $4,$2,$2 -> o_stall=1,o_bubble=1 one cycle; then add issues
//    with o_fwdA=o_fwdB=10; o_stall_count 0->1.
//  4 add $3 ; add $3 ; sub $5,$3,$3 -> newest wins: o_fwdA=o_fwdB=01.
//  5 write to $0 followed by reader of $0; lw $2 followed by use with i_flush=1 same
//    cycle -> selects 00, o_stall=0, counter unchanged.
//  6 i_enable=0 during hazard -> state/outputs frozen; force counter to max, stall again
//    -> stays all-ones; assert i_reset mid-stall -> selects 00, o_stall=0 at once.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the EX-stage forwarding path.
// Select codes are also decoded by the EX operand muxes.
package hazard_forward_unit_pkg;

    localparam int NB_REG = 5;

    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_tag_stage.sv
// One pipeline stage of destination tags.
// Holds {valid, rd, regWrite, memRead}; freezes when disabled.
module hazard_tag_stage #(
    parameter int NB_REG = 5
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_valid,
    input  logic [NB_REG-1:0] i_rd,
    input  logic              i_reg_write,
    input  logic              i_mem_read,
    output logic              o_valid,
    output logic [NB_REG-1:0] o_rd,
    output logic              o_reg_write,
    output logic              o_mem_read
);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_valid     <= 1'b0;
            o_rd        <= '0;
            o_reg_write <= 1'b0;
            o_mem_read  <= 1'b0;
        end else if (i_enable) begin
            o_valid     <= i_valid;
            o_rd        <= i_rd;
            o_reg_write <= i_reg_write;
            o_mem_read  <= i_mem_read;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding select and load-use stall generator.
// Selects are registered alongside ID/EX for the consumer's EX cycle.
import hazard_forward_unit_pkg::*;

module hazard_forward_unit #(
    parameter int NB_REG = hazard_forward_unit_pkg::NB_REG,
    parameter int NB_CNT = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_id_valid,
    input  logic [NB_REG-1:0] i_id_rs,
    input  logic [NB_REG-1:0] i_id_rt,
    input  logic [NB_REG-1:0] i_id_rd,
    input  logic              i_id_regWrite,
    input  logic              i_id_memRead,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_bubble,
    output logic [1:0]        o_fwdA,
    output logic [1:0]        o_fwdB,
    output logic [NB_CNT-1:0] o_stall_count
);

    localparam logic [NB_CNT-1:0] CNT_MAX = '1;

    logic              ex_valid;
    logic [NB_REG-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;

    logic              mem_valid;
    logic [NB_REG-1:0] mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;

    logic [NB_REG+2:0] unused_wb_tag;

    logic ex_in_valid;
    logic hazard;
    logic ex_match_a;
    logic ex_match_b;
    logic mem_match_a;
    logic mem_match_b;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    assign ex_in_valid = i_id_valid & ~o_bubble;

    hazard_tag_stage #(.NB_REG(NB_REG)) u_ex (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_valid     (ex_in_valid),
        .i_rd        (i_id_rd),
        .i_reg_write (i_id_regWrite),
        .i_mem_read  (i_id_memRead),
        .o_valid     (ex_valid),
        .o_rd        (ex_rd),
        .o_reg_write (ex_reg_write),
        .o_mem_read  (ex_mem_read)
    );

    hazard_tag_stage #(.NB_REG(NB_REG)) u_mem (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_valid     (ex_valid),
        .i_rd        (ex_rd),
        .i_reg_write (ex_reg_write),
        .i_mem_read  (ex_mem_read),
        .o_valid     (mem_valid),
        .o_rd        (mem_rd),
        .o_reg_write (mem_reg_write),
        .o_mem_read  (mem_mem_read)
    );

    // WB tags are kept for the debug view only; no consumer here.
    hazard_tag_stage #(.NB_REG(NB_REG)) u_wb (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_valid     (mem_valid),
        .i_rd        (mem_rd),
        .i_reg_write (mem_reg_write),
        .i_mem_read  (mem_mem_read),
        .o_valid     (unused_wb_tag[NB_REG+2]),
        .o_rd        (unused_wb_tag[NB_REG+1:2]),
        .o_reg_write (unused_wb_tag[1]),
        .o_mem_read  (unused_wb_tag[0])
    );

    assign hazard = i_id_valid & ex_valid & ex_mem_read
                  & (ex_rd != '0)
                  & ((ex_rd == i_id_rs) | (ex_rd == i_id_rt));

    assign o_stall  = hazard & ~i_flush;
    assign o_bubble = hazard | i_flush;

    assign ex_match_a = ex_valid & ex_reg_write
                      & (ex_rd == i_id_rs) & (i_id_rs != '0);
    assign ex_match_b = ex_valid & ex_reg_write
                      & (ex_rd == i_id_rt) & (i_id_rt != '0);
    assign mem_match_a = mem_valid & mem_reg_write
                       & (mem_rd == i_id_rs) & (i_id_rs != '0);
    assign mem_match_b = mem_valid & mem_reg_write
                       & (mem_rd == i_id_rt) & (i_id_rt != '0);

    // Producer in EX now sits in MEM during the consumer's EX cycle.
    always_comb begin
        sel_a = FWD_ID;
        sel_b = FWD_ID;
        if (ex_match_a)       sel_a = FWD_MEM;
        else if (mem_match_a) sel_a = FWD_WB;
        if (ex_match_b)       sel_b = FWD_MEM;
        else if (mem_match_b) sel_b = FWD_WB;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_fwdA <= FWD_ID;
            o_fwdB <= FWD_ID;
        end else if (i_enable) begin
            if (o_bubble | ~i_id_valid) begin
                o_fwdA <= FWD_ID;
                o_fwdB <= FWD_ID;
            end else begin
                o_fwdA <= sel_a;
                o_fwdB <= sel_b;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_stall_count <= '0;
        end else if (i_enable && o_stall && o_stall_count != CNT_MAX) begin
            o_stall_count <= o_stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit with a select scoreboard.
// Counter is narrowed so saturation is reachable in a short run.
module tb_hazard_forward_unit;

    localparam int NB_REG = 5;
    localparam int NB_CNT = 4;

    logic              i_clock;
    logic              i_reset;
    logic              i_enable;
    logic              i_id_valid;
    logic [NB_REG-1:0] i_id_rs;
    logic [NB_REG-1:0] i_id_rt;
    logic [NB_REG-1:0] i_id_rd;
    logic              i_id_regWrite;
    logic              i_id_memRead;
    logic              i_flush;
    logic              o_stall;
    logic              o_bubble;
    logic [1:0]        o_fwdA;
    logic [1:0]        o_fwdB;
    logic [NB_CNT-1:0] o_stall_count;

    int total = 0;
    int bad   = 0;
    logic [3:0] sb[$];

    hazard_forward_unit #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_id_valid    (i_id_valid),
        .i_id_rs       (i_id_rs),
        .i_id_rt       (i_id_rt),
        .i_id_rd       (i_id_rd),
        .i_id_regWrite (i_id_regWrite),
        .i_id_memRead  (i_id_memRead),
        .i_flush       (i_flush),
        .o_stall       (o_stall),
        .o_bubble      (o_bubble),
        .o_fwdA        (o_fwdA),
        .o_fwdB        (o_fwdB),
        .o_stall_count (o_stall_count)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        i_id_valid    = v;
        i_id_rs       = rs;
        i_id_rt       = rt;
        i_id_rd       = rd;
        i_id_regWrite = rw;
        i_id_memRead  = mr;
        i_flush       = fl;
    endtask

    task automatic pop_chk(input string tag);
        logic [3:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_fwdA"}, {30'd0, o_fwdA}, {30'd0, e[3:2]});
            chk({tag, "_fwdB"}, {30'd0, o_fwdB}, {30'd0, e[1:0]});
        end
    endtask

    task automatic issue(input string tag, input logic v,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic rw,
                         input logic mr, input logic fl,
                         input logic es, input logic eb,
                         input logic [1:0] ea, input logic [1:0] eb2);
        drive(v, rs, rt, rd, rw, mr, fl);
        #1;
        chk({tag, "_stall"}, {31'd0, o_stall}, {31'd0, es});
        chk({tag, "_bubble"}, {31'd0, o_bubble}, {31'd0, eb});
        sb.push_back({ea, eb2});
        @(posedge i_clock);
        #1;
        pop_chk(tag);
    endtask

    task automatic nop2();
        issue("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        issue("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    endtask

    initial begin
        i_reset  = 1'b0;
        i_enable = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge i_clock);
        @(posedge i_clock);
        #1;
        chk("rst_fwdA", {30'd0, o_fwdA}, 32'd0);
        chk("rst_fwdB", {30'd0, o_fwdB}, 32'd0);
        chk("rst_cnt", {28'd0, o_stall_count}, 32'd0);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;

        // EX->EX forward on A
        issue("t1_add", 1, 1, 2, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        issue("t1_sub", 1, 3, 5, 4, 1, 0, 0, 0, 0, 2'b01, 2'b00);
        nop2();

        // MEM->EX forward on B across a nop
        issue("t2_add", 1, 1, 2, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        issue("t2_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        issue("t2_or", 1, 7, 3, 6, 1, 0, 0, 0, 0, 2'b00, 2'b10);
        nop2();

        // load-use: one stall, then WB forward on both
        issue("t3_lw", 1, 1, 2, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        chk("t3_cnt0", {28'd0, o_stall_count}, 32'd0);
        issue("t3_stl", 1, 2, 2, 4, 1, 0, 0, 1, 1, 2'b00, 2'b00);
        issue("t3_add", 1, 2, 2, 4, 1, 0, 0, 0, 0, 2'b10, 2'b10);
        chk("t3_cnt1", {28'd0, o_stall_count}, 32'd1);
        nop2();

        // newest producer wins
        issue("t4_a1", 1, 1, 2, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        issue("t4_a2", 1, 1, 2, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        issue("t4_sub", 1, 3, 3, 5, 1, 0, 0, 0, 0, 2'b01, 2'b01);
        nop2();

        // $0 never forwarded; load to $0 never stalls
        issue("t5_w0", 1, 1, 2, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        issue("t5_r0", 1, 0, 0, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        issue("t5_lw0", 1, 1, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        issue("t5_u0", 1, 0, 0, 8, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        nop2();

        // flush beats hazard
        issue("t5_lw", 1, 1, 2, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        issue("t5_fl", 1, 2, 2, 4, 1, 0, 1, 0, 1, 2'b00, 2'b00);
        chk("t5_cnt", {28'd0, o_stall_count}, 32'd1);
        nop2();

        // freeze during hazard
        issue("t6_a1", 1, 5, 6, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        issue("t6_lw", 1, 1, 2, 2, 1, 1, 0, 0, 0, 2'b01, 2'b00);
        i_enable = 1'b0;
        drive(1, 2, 2, 4, 1, 0, 0);
        #1;
        chk("t6_frz_stall", {31'd0, o_stall}, 32'd1);
        chk("t6_frz_bub", {31'd0, o_bubble}, 32'd1);
        sb.push_back({2'b01, 2'b00});
        @(posedge i_clock);
        @(posedge i_clock);
        #1;
        pop_chk("t6_frz");
        chk("t6_frz_stall2", {31'd0, o_stall}, 32'd1);
        chk("t6_frz_cnt", {28'd0, o_stall_count}, 32'd1);
        i_enable = 1'b1;
        issue("t6_stl", 1, 2, 2, 4, 1, 0, 0, 1, 1, 2'b00, 2'b00);
        chk("t6_cnt2", {28'd0, o_stall_count}, 32'd2);
        issue("t6_add", 1, 2, 2, 4, 1, 0, 0, 0, 0, 2'b10, 2'b10);

        // drive counter to saturation and beyond
        for (int i = 0; i < 14; i++) begin
            nop2();
            issue("sat_lw", 1, 1, 2, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00);
            issue("sat_stl", 1, 2, 2, 4, 1, 0, 0, 1, 1, 2'b00, 2'b00);
            issue("sat_add", 1, 2, 2, 4, 1, 0, 0, 0, 0, 2'b10, 2'b10);
            chk("sat_cnt", {28'd0, o_stall_count},
                (i + 3 > 15) ? 32'd15 : i + 3);
        end
        nop2();

        // async reset while stalled
        issue("t7_a1", 1, 5, 6, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        issue("t7_lw", 1, 1, 2, 2, 1, 1, 0, 0, 0, 2'b01, 2'b00);
        drive(1, 2, 2, 4, 1, 0, 0);
        #1;
        chk("t7_stall", {31'd0, o_stall}, 32'd1);
        #2;
        i_reset = 1'b0;
        #1;
        chk("t7_rst_stall", {31'd0, o_stall}, 32'd0);
        chk("t7_rst_fwdA", {30'd0, o_fwdA}, 32'd0);
        chk("t7_rst_fwdB", {30'd0, o_fwdB}, 32'd0);
        chk("t7_rst_cnt", {28'd0, o_stall_count}, 32'd0);
        #1;
        i_reset = 1'b1;
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
